// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Single-byte SPI initiator, mode 0 framing: sclk idles low, mosi is driven
//   MSB first and changes on sclk falling edges. miso is collected LSB first;
//   each bit is sampled in the last clk cycle of the low phase that follows a
//   falling edge, which matches the transmit order of the companion SPI slave.
//
//   Frame from an accept in cycle T (CLK_DIV = clk cycles per sclk half period):
//     SETUP, 8 x HIGH, 7 x LOW, HOLD, GAP -- every phase lasts CLK_DIV cycles.
//     ss_n falls at T+1, the first sclk rise is at T+1+CLK_DIV, done and ss_n
//     high arrive at T+1+17*CLK_DIV, and busy drops at T+1+18*CLK_DIV.
//
//   Optional build macro: SPI_MASTER_ABORT_EN
//     Adds an 'abort' input. An abort seen in SETUP, HIGH, LOW or HOLD drops the
//     frame: pins return to idle on the next cycle and the FSM spends a full
//     GAP phase before going idle, with no done pulse and rx_data unchanged.
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
`ifdef SPI_MASTER_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       sclk,
    output logic       mosi,
    output logic       ss_n,
    input  logic       miso
);

    // Half-period counter width; CLK_DIV >= 2 so this is at least one bit.
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_cnt_q;
    // Only the seven bits still to be sent are kept; bit 7 goes straight to mosi.
    logic [6:0]      shift_tx_q;
    // Bits 0..6 of the incoming byte; bit 7 is taken live from miso at HOLD end.
    logic [6:0]      rx_shift_q;
    logic            sclk_q;
    logic            mosi_q;
    logic            ss_n_q;
    logic            busy_q;
    logic            done_q;
    logic [7:0]      rx_data_q;

    logic            phase_end_s;

    assign phase_end_s = (cnt_q == CNT_LAST);

`ifdef SPI_MASTER_ABORT_EN
    logic            abort_hit_s;

    // An abort only matters while a frame is actually on the wire.
    always_comb begin
        abort_hit_s = 1'b0;
        case (state_q)
            ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD: abort_hit_s = abort;
            default:                            abort_hit_s = 1'b0;
        endcase
    end
`endif

    // Frame sequencer: state, half-period timing, shift registers and all pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= 3'd0;
            shift_tx_q <= 7'd0;
            rx_shift_q <= 7'd0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= 8'h00;
        end
`ifdef SPI_MASTER_ABORT_EN
        else if (abort_hit_s) begin
            // Drop the frame; GAP still gives the slave a full ss_n-high phase.
            state_q <= ST_GAP;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end
`endif
        else begin
            done_q <= 1'b0;

            // The counter idles at zero and wraps at the end of every phase.
            if (state_q == ST_IDLE) begin
                cnt_q <= '0;
            end else if (phase_end_s) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shift_tx_q <= tx_data[6:0];
                        mosi_q     <= tx_data[7];
                        ss_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        bit_cnt_q  <= 3'd0;
                        state_q    <= ST_SETUP;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_SETUP: begin
                    // mosi has had a full half period to settle before the rise.
                    if (phase_end_s) begin
                        sclk_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end else begin
                        state_q <= ST_SETUP;
                    end
                end

                ST_HIGH: begin
                    if (phase_end_s) begin
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_HOLD;
                        end else begin
                            mosi_q     <= shift_tx_q[6];
                            shift_tx_q <= {shift_tx_q[5:0], 1'b0};
                            state_q    <= ST_LOW;
                        end
                    end else begin
                        state_q <= ST_HIGH;
                    end
                end

                ST_LOW: begin
                    // bit_cnt already counts the falling edge just taken, so the
                    // bit answering fall k (k = 0..6) lands at index k.
                    if (phase_end_s) begin
                        rx_shift_q[bit_cnt_q - 3'd1] <= miso;
                        sclk_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end else begin
                        state_q <= ST_LOW;
                    end
                end

                ST_HOLD: begin
                    // Eighth sample point: bit 7 comes straight from miso.
                    if (phase_end_s) begin
                        rx_data_q <= {miso, rx_shift_q};
                        done_q    <= 1'b1;
                        ss_n_q    <= 1'b1;
                        mosi_q    <= 1'b0;
                        state_q   <= ST_GAP;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end

                ST_GAP: begin
                    // Guarantees ss_n stays high for at least CLK_DIV cycles.
                    if (phase_end_s) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_GAP;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    sclk_q  <= 1'b0;
                    mosi_q  <= 1'b0;
                    ss_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Directed bench for spi_master (CLK_DIV = 4) with a behavioural SPI slave.
//   Each accepted transfer pushes its expected master rx byte and the byte the
//   slave should capture; a monitor pops and compares on every done pulse.
//   Build with SPI_MASTER_ABORT_EN defined to include the abort scenario.
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sclk;
    logic       mosi;
    logic       ss_n;
    logic       miso = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    logic       abort;
`endif

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    // Behavioural slave state
    logic       sclk_d = 1'b0;
    logic       pend   = 1'b0;
    logic [2:0] fidx   = 3'd0;
    logic [7:0] s_rx   = 8'h00;
    logic [7:0] slave_byte;
    int         rises  = 0;
    int         falls  = 0;
    bit         mosi_log[$];

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
`ifdef SPI_MASTER_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .mosi    (mosi),
        .ss_n    (ss_n),
        .miso    (miso)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pins();
        return {19'd0, sclk, ss_n, mosi, busy, done, rx_data};
    endfunction

    task automatic push_exp(input logic [7:0] r, input logic [7:0] t);
        exp_rx.push_back(r);
        exp_tx.push_back(t);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still %b after 400 cycles, required 0", name, busy);
        end
    endtask

    // Slave: capture mosi on rises (MSB first), present byte bit k 2 cycles after fall k.
    always @(posedge clk) begin
        sclk_d <= sclk;
        if (rst === 1'b1 || ss_n !== 1'b0) begin
            fidx  <= 3'd0;
            pend  <= 1'b0;
            rises <= 0;
            falls <= 0;
        end else begin
            if (sclk === 1'b1 && sclk_d === 1'b0) begin
                s_rx  <= {s_rx[6:0], mosi};
                mosi_log.push_back(mosi);
                rises <= rises + 1;
            end
            if (sclk === 1'b0 && sclk_d === 1'b1) begin
                pend  <= 1'b1;
                falls <= falls + 1;
            end else begin
                pend <= 1'b0;
            end
            if (pend) begin
                miso <= slave_byte[fidx];
                fidx <= fidx + 3'd1;
            end
        end
    end

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with rx_data=0x%0h, required no done", rx_data);
            end else begin
                logic [7:0] e_rx;
                logic [7:0] e_tx;
                e_rx = exp_rx.pop_front();
                e_tx = exp_tx.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e_rx});
                check("slave_rx", {24'd0, s_rx}, {24'd0, e_tx});
                check("sclk_rises", rises, 32'd8);
                check("ss_n_at_done", {31'd0, ss_n}, 32'd1);
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rise;
        int done_at;
        int busy_lo;
        int d0;
        logic ssn_done;
        logic [7:0] mb;

        rst        = 1'b1;
        start      = 1'b0;
        tx_data    = 8'h00;
        slave_byte = 8'h00;
`ifdef SPI_MASTER_ABORT_EN
        abort      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset / idle: pins quiet for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_pins", pins(), 32'h0000_0800);
        end

        // TX framing and RX capture: send 0xA5, slave returns 0x3C
        @(negedge clk);
        mosi_log.delete();
        tx_data    = 8'hA5;
        slave_byte = 8'h3C;
        push_exp(8'h3C, 8'hA5);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ss_n_T1", {31'd0, ss_n}, 32'd0);
        check("busy_T1", {31'd0, busy}, 32'd1);
        check("sclk_T1", {31'd0, sclk}, 32'd0);
        first_rise = -1;
        done_at    = -1;
        busy_lo    = -1;
        ssn_done   = 1'b0;
        for (int k = 2; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (sclk === 1'b1 && first_rise < 0) first_rise = k;
            if (done === 1'b1 && done_at < 0) begin
                done_at  = k;
                ssn_done = ss_n;
            end
            if (busy === 1'b0 && busy_lo < 0) busy_lo = k;
        end
        check("first_rise_cycle", 32'(first_rise), 32'd5);
        check("done_cycle", 32'(done_at), 32'd69);
        check("ss_n_high_at_done", {31'd0, ssn_done}, 32'd1);
        check("busy_low_cycle", 32'(busy_lo), 32'd73);
        check("mosi_bit_count", 32'(mosi_log.size()), 32'd8);
        mb = 8'h00;
        for (int i = 0; i < mosi_log.size() && i < 8; i++) mb = {mb[6:0], mosi_log[i]};
        check("mosi_bits", {24'd0, mb}, 32'h0000_00A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rx_data_held", {24'd0, rx_data}, 32'h0000_003C);
        end

        // Busy rules: start pulses and tx_data=0xFF while busy are ignored
        @(negedge clk);
        d0         = done_cnt;
        tx_data    = 8'h5A;
        slave_byte = 8'h96;
        push_exp(8'h96, 8'h5A);
        start      = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 400 && busy === 1'b1; n++) begin
            start   = 1'b1;
            tx_data = 8'hFF;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_released", {31'd0, busy}, 32'd0);
        check("busy_one_done", 32'(done_cnt - d0), 32'd1);

        // start held high: second transfer accepted in the first idle cycle
        @(negedge clk);
        d0         = done_cnt;
        tx_data    = 8'h5A;
        slave_byte = 8'hE7;
        push_exp(8'hE7, 8'h5A);
        push_exp(8'hE7, 8'h11);
        start      = 1'b1;
        @(negedge clk);
        check("held_accept1", {31'd0, busy}, 32'd1);
        tx_data = 8'h11;
        for (int n = 0; n < 400 && busy === 1'b1; n++) @(negedge clk);
        check("held_idle_cycle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("held_reaccept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_idle("held_second");
        check("held_two_dones", 32'(done_cnt - d0), 32'd2);

        // Reset after the 3rd rising edge drops the frame
        @(negedge clk);
        d0         = done_cnt;
        tx_data    = 8'h77;
        slave_byte = 8'h55;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 400 && rises < 3; n++) @(negedge clk);
        check("rises_before_reset", 32'(rises), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_midop_pins", pins(), 32'h0000_0800);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_no_done", 32'(done_cnt - d0), 32'd0);
        tx_data    = 8'h81;
        slave_byte = 8'h24;
        push_exp(8'h24, 8'h81);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("after_reset_xfer");

        // Slave sends 0x5A while master sends 0xC3
        @(negedge clk);
        tx_data    = 8'hC3;
        slave_byte = 8'h5A;
        push_exp(8'h5A, 8'hC3);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("integration_xfer");

`ifdef SPI_MASTER_ABORT_EN
        // Abort after the 2nd falling edge: pins idle next cycle, no done
        @(negedge clk);
        d0         = done_cnt;
        tx_data    = 8'h99;
        slave_byte = 8'hFF;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 400 && falls < 2; n++) @(negedge clk);
        check("falls_before_abort", 32'(falls), 32'd2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_pins", pins(), 32'h0000_0A5A);
        wait_idle("abort_gap");
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_rx_kept", {24'd0, rx_data}, 32'h0000_005A);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_rx.size()), 32'd0);
        check("done_total", 32'(done_cnt), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI initiator (mode 0 framing: sclk idles low, mosi driven MSB first).
- Drives sclk/mosi/ss_n toward the team's SPI slave block and collects miso.
- miso is captured LSB first, after each sclk falling edge, to match the slave's transmit order.
- Sits between a local command interface (start/tx_data/done/rx_data) and the external SPI pins.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period. Legal range ≥2; must be ≥4 when talking to the slave block, which has a 3-cycle input/edge pipeline.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a transfer; accepted only when busy=0
- tx_data  input  8  byte to send; sampled in the accept cycle
- busy  output  1  high from the cycle after accept until return to IDLE
- done  output  1  one-cycle pulse when rx_data is valid
- rx_data  output  8  last received byte; held until the next done
- sclk  output  1  SPI clock
- mosi  output  1  SPI data out
- ss_n  output  1  SPI select, active low
- miso  input  1  SPI data in; assumed synchronous to clk

Behaviour:
- Reset (rst=1 at a clk edge, including mid-transfer): state=IDLE, sclk=0, mosi=0, ss_n=1, busy=0, done=0, rx_data=0x00, counters=0. Any transfer in progress is dropped with no done pulse.
- All outputs are registered. A half-period counter runs 0..CLK_DIV-1 in every non-IDLE state; a phase ends when the counter reaches CLK_DIV-1.
- States: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE, start=1 in cycle T:
  - load shift_tx=tx_data; mosi<=tx_data[7]; ss_n<=0; busy<=1; bit_cnt<=0; go to SETUP.
  - All of these are visible at T+1.
- SETUP end: sclk<=1; go to HIGH. First rising edge at T+1+CLK_DIV.
- HIGH end:
  - sclk<=0; bit_cnt<=bit_cnt+1.
  - If bit_cnt==7, go to HOLD.
  - Otherwise mosi<=next lower tx bit; go to LOW.
- LOW end: rx_shift[bit_cnt-1]<=miso; sclk<=1; go to HIGH.
- HOLD end:
  - rx_shift[7]<=miso.
  - rx_data<=complete byte (bit 7 taken from the current miso).
  - done<=1 for exactly one cycle; ss_n<=1; mosi<=0; go to GAP.
- GAP end: busy<=0; go to IDLE. GAP guarantees the slave sees ss_n high for ≥CLK_DIV cycles.
- Sample points:
  - exactly 8 miso samples per byte, each at the last cycle of a LOW or HOLD phase, i.e. CLK_DIV-1 cycles after the corresponding falling edge;
  - miso bit k is stored at rx_data[k].
- Timing: 8 rising and 8 falling edges per byte.
  - ss_n low at T+1
  - done and ss_n high at T+1+17*CLK_DIV
  - busy low at T+1+18*CLK_DIV
  - next accept possible in that same cycle
- start while busy=1: ignored, no queuing. start held high continuously: a new transfer begins in the first IDLE cycle.
- tx_data changes after the accept cycle: no effect on the current byte.
- bit_cnt is 3 bits and never wraps within a byte; the HIGH end with bit_cnt==7 is the only path to HOLD.

Optional Feature:
- Macro: SPI_MASTER_ABORT_EN.
- When defined:
  - adds input abort (1 bit).
  - abort=1 in any of SETUP, HIGH, LOW or HOLD: next cycle sclk=0, mosi=0, ss_n=1, state=GAP with a fresh counter, no done pulse, rx_data unchanged.
  - abort in IDLE or GAP: ignored.
  - abort and start in the same IDLE cycle: start wins.
- When undefined: no abort port and no abort logic. Behaviour is exactly as specified above.

Test Plan:
- Reset/idle: rst held 3 cycles then released, no start → sclk=0, ss_n=1, mosi=0, busy=0, done=0, rx_data=0x00 for 20 cycles.
- TX framing (CLK_DIV=4): start with tx_data=0xA5 at T → ss_n=0 at T+1; mosi sampled at the 8 sclk rising edges = 1,0,1,0,0,1,0,1; first rise at T+5; done at T+69 with ss_n=1; busy=0 at T+73.
- RX capture: behavioural slave drives miso with bits of 0x3C, LSB first, 2 cycles after each falling edge → rx_data=0x3C at the done cycle; rx_data held through the following idle.
- Busy rules: start pulses every cycle while busy, tx_data changed to 0xFF mid-byte → only 0x5A (accepted value) shifted out, exactly one done; start held high → second transfer accepted in the cycle busy falls.
- Reset mid-operation: rst asserted after the 3rd rising edge → next cycle ss_n=1, sclk=0, busy=0, no done; a following start with 0x81 completes normally.
- Integration with the SPI slave block (slave send_item=0x5A, CLK_DIV=4): master sends 0xC3 → master rx_data=0x5A; slave's received byte is 0xC3. With SPI_MASTER_ABORT_EN, abort after the 2nd falling edge → ss_n=1 next cycle, no done.
